// File: rtl/bram_fifo_ctrl_if.sv
// Push/pop handshake between user logic (master) and the BRAM FIFO controller (slave).
interface bram_fifo_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              flush;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, push, push_data, pop,
    input  pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );

  modport slave (
    input  flush, push, push_data, pop,
    output pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow
  );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller driving a simple dual-port BRAM as a circular buffer.
// Optional macro BRAM_FIFO_OUTREG_EN enables the BRAM output register (read latency 2).
module bram_fifo_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int AFULL_TH = 60
) (
  input  logic              clk,
  input  logic              RST_N,
  bram_fifo_ctrl_if.slave   fif,
  output logic [ADDR_W-1:0] WRADDR,
  output logic              WREN,
  output logic              WE,
  output logic [DATA_W-1:0] DI,
  output logic [ADDR_W-1:0] RDADDR,
  output logic              RDEN,
  output logic              REGCE,
  output logic              RST,
  input  logic [DATA_W-1:0] DO
);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          state_r;
  logic            init_cnt_r;
  logic [ADDR_W:0] wr_ptr_r;
  logic [ADDR_W:0] rd_ptr_r;
  logic            ovf_r;
  logic            udf_r;
  logic            vld_r;
`ifdef BRAM_FIFO_OUTREG_EN
  logic            stg1_r;
`endif

  logic [ADDR_W:0] count_s;
  logic            ptr_full_s;
  logic            ptr_empty_s;
  logic            ready_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic            pop_valid_s;

  // Occupancy from pointer difference; requests are accepted only in READY and never alongside flush
  always_comb begin
    count_s     = wr_ptr_r - rd_ptr_r;
    ptr_empty_s = (wr_ptr_r == rd_ptr_r);
    ptr_full_s  = (wr_ptr_r[ADDR_W-1:0] == rd_ptr_r[ADDR_W-1:0]) &&
                  (wr_ptr_r[ADDR_W] != rd_ptr_r[ADDR_W]);
    ready_s     = (state_r == ST_READY);
    wr_en_s     = ready_s && fif.push && !ptr_full_s && !fif.flush;
    rd_en_s     = ready_s && fif.pop && !ptr_empty_s && !fif.flush;
  end

  // User flags and BRAM strobes; addresses and write data are zero when the port is idle
  always_comb begin
    WREN = wr_en_s;
    WE   = wr_en_s;
    RDEN = rd_en_s;
    RST  = !ready_s;
    if (wr_en_s) begin
      WRADDR = wr_ptr_r[ADDR_W-1:0];
      DI     = fif.push_data;
    end else begin
      WRADDR = {ADDR_W{1'b0}};
      DI     = {DATA_W{1'b0}};
    end
    if (rd_en_s) begin
      RDADDR = rd_ptr_r[ADDR_W-1:0];
    end else begin
      RDADDR = {ADDR_W{1'b0}};
    end
    if (ready_s) begin
      fif.full  = ptr_full_s;
      fif.empty = ptr_empty_s;
    end else begin
      fif.full  = 1'b1;
      fif.empty = 1'b1;
    end
    fif.count       = count_s;
    fif.almost_full = (count_s >= AFULL_TH[ADDR_W:0]);
    fif.overflow    = ovf_r;
    fif.underflow   = udf_r;
    // flush in the cycle a read lands cancels it so no stale word escapes
    pop_valid_s   = vld_r && !fif.flush;
    fif.pop_valid = pop_valid_s;
    if (pop_valid_s) begin
      fif.pop_data = DO;
    end else begin
      fif.pop_data = {DATA_W{1'b0}};
    end
`ifdef BRAM_FIFO_OUTREG_EN
    REGCE = stg1_r && !fif.flush;
`else
    REGCE = 1'b0;
`endif
  end

  // INIT/READY sequencing, pointers, sticky flags and the read-valid pipeline
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_INIT;
      init_cnt_r <= 1'b0;
      wr_ptr_r   <= {(ADDR_W+1){1'b0}};
      rd_ptr_r   <= {(ADDR_W+1){1'b0}};
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
      vld_r      <= 1'b0;
`ifdef BRAM_FIFO_OUTREG_EN
      stg1_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_INIT: begin
          init_cnt_r <= 1'b1;
          if (init_cnt_r) begin
            state_r <= ST_READY;
          end
        end
        ST_READY: state_r <= ST_READY;
        default:  state_r <= ST_INIT;
      endcase

      if (fif.flush) begin
        wr_ptr_r <= {(ADDR_W+1){1'b0}};
        rd_ptr_r <= {(ADDR_W+1){1'b0}};
        ovf_r    <= 1'b0;
        udf_r    <= 1'b0;
        vld_r    <= 1'b0;
`ifdef BRAM_FIFO_OUTREG_EN
        stg1_r   <= 1'b0;
`endif
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (rd_en_s) begin
          rd_ptr_r <= rd_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
        end
        if (ready_s && fif.push && ptr_full_s) begin
          ovf_r <= 1'b1;
        end
        if (ready_s && fif.pop && ptr_empty_s) begin
          udf_r <= 1'b1;
        end
`ifdef BRAM_FIFO_OUTREG_EN
        stg1_r <= rd_en_s;
        vld_r  <= stg1_r;
`else
        vld_r  <= rd_en_s;
`endif
      end
    end
  end

endmodule
